// File: rtl/tensor_mem_slave.sv
// AXI-lite style word memory slave: one outstanding read, independent AW/W capture,
// read-first collision behaviour and a sticky address-error flag.
module tensor_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic                  addr_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    r_state_t              state, state_nx;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  ar_fire, r_fire, aw_fire, w_fire, commit;

    function automatic logic legal(input logic [ADDR_WIDTH-1:0] a);
        return ((a & OFF_MASK) == '0) && ((a >> OFF) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] w;
        w = a >> OFF;
        return w[IDX_W-1:0];
    endfunction

    assign ar_fire     = axi_arvalid && axi_arready;
    assign r_fire      = axi_rvalid && axi_rready;
    assign aw_fire     = axi_awvalid && !aw_held;
    assign w_fire      = axi_wvalid && !w_held;
    assign commit      = aw_held && w_held;
    assign axi_awready = !aw_held;
    assign axi_wready  = !w_held;

    // Read FSM
    always_comb begin
        state_nx    = state;
        axi_arready = (state == R_IDLE);
        case (state)
            R_IDLE:  if (axi_arvalid) state_nx = R_RESP;
            R_RESP:  if (axi_rready)  state_nx = R_IDLE;
            default: state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= R_IDLE;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (ar_fire) begin
                axi_rvalid <= 1'b1;
                // mem is read before this edge's commit lands, giving read-first ordering
                axi_rdata  <= legal(axi_araddr) ? mem[index(axi_araddr)] : '0;
            end else if (r_fire) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

    // Write capture: each channel latches on its own handshake, commit when both are held
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= axi_awaddr;
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= axi_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && legal(aw_addr))
            mem[index(aw_addr)] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            addr_err <= 1'b0;
        else if ((ar_fire && !legal(axi_araddr)) || (aw_fire && !legal(axi_awaddr)))
            addr_err <= 1'b1;
    end

endmodule

// File: tb/tb_tensor_mem_slave.sv
// Directed bench for tensor_mem_slave: reset, write/read, split write, backpressure,
// illegal addresses, read/write collision and mid-operation reset.
module tb_tensor_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, addr_err;

    int checks = 0;
    int errors = 0;

    tensor_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        axi_awaddr = a; axi_wdata = d; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        step();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        chk("commit_awready", axi_awready, 32'd0);
        chk("commit_wready", axi_wready, 32'd0);
        step();
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        axi_araddr = a; axi_arvalid = 1'b1;
        chk({tag, "_arready"}, axi_arready, 32'd1);
        step();
        axi_arvalid = 1'b0;
        chk({tag, "_rvalid"}, axi_rvalid, 32'd1);
        chk({tag, "_rdata"}, axi_rdata, exp);
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
        chk({tag, "_rvalid_clr"}, axi_rvalid, 32'd0);
        chk({tag, "_idle"}, axi_arready, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wvalid = 1'b0;
        step(); step();
        chk("rst_rvalid", axi_rvalid, 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        chk("rst_arready", axi_arready, 32'd1);
        chk("rst_awready", axi_awready, 32'd1);
        chk("rst_wready", axi_wready, 32'd1);
        chk("rst_addr_err", addr_err, 32'd0);
        rst = 1'b0;
        step();

        // write then read, both channels in one cycle
        wr(32'h10, 32'hDEADBEEF);
        chk("wr_ready_back", axi_awready & axi_wready, 32'd1);
        rd("rd10", 32'h10, 32'hDEADBEEF);

        // split write: W first, AW four cycles later
        axi_wdata = 32'h12345678; axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("split_wready", axi_wready, 32'd0);
            chk("split_awready", axi_awready, 32'd1);
            step();
        end
        chk("split_wready_last", axi_wready, 32'd0);
        axi_awaddr = 32'h20; axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        chk("split_commit_aw", axi_awready, 32'd0);
        chk("split_commit_w", axi_wready, 32'd0);
        step();
        chk("split_after_aw", axi_awready, 32'd1);
        chk("split_after_w", axi_wready, 32'd1);
        rd("rd20", 32'h20, 32'h12345678);

        // read backpressure
        axi_araddr = 32'h10; axi_arvalid = 1'b1;
        step();
        axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rvalid", axi_rvalid, 32'd1);
            chk("bp_rdata", axi_rdata, 32'hDEADBEEF);
            chk("bp_arready", axi_arready, 32'd0);
            step();
        end
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
        chk("bp_rvalid_clr", axi_rvalid, 32'd0);
        chk("bp_idle", axi_arready, 32'd1);

        // illegal addresses
        wr(32'h0, 32'h55);
        chk("pre_err", addr_err, 32'd0);
        rd("rd_oob", 32'h1000, 32'h0);
        chk("oob_err", addr_err, 32'd1);
        wr(32'h3, 32'hAAAA);
        chk("misalign_err", addr_err, 32'd1);
        rd("rd0", 32'h0, 32'h55);
        rd("rd_last", 32'hFFC, 32'h0 | 32'h0);

        // collision: AR accepted on the commit edge sees old data
        wr(32'h40, 32'h1);
        axi_awaddr = 32'h40; axi_wdata = 32'h2; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        step();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        rd("rd40_old", 32'h40, 32'h1);
        rd("rd40_new", 32'h40, 32'h2);
        chk("err_sticky", addr_err, 32'd1);

        // reset during R_RESP with only AW held
        wr(32'h80, 32'h77);
        axi_araddr = 32'h80; axi_arvalid = 1'b1;
        axi_awaddr = 32'h80; axi_awvalid = 1'b1;
        step();
        axi_arvalid = 1'b0; axi_awvalid = 1'b0;
        chk("mid_rvalid", axi_rvalid, 32'd1);
        chk("mid_aw_held", axi_awready, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_rvalid", axi_rvalid, 32'd0);
        chk("mid_rst_arready", axi_arready, 32'd1);
        chk("mid_rst_awready", axi_awready, 32'd1);
        chk("mid_rst_wready", axi_wready, 32'd1);
        chk("mid_rst_err", addr_err, 32'd0);
        axi_wdata = 32'h99; axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        axi_awaddr = 32'h84; axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        step();
        rd("rd80", 32'h80, 32'h77);
        rd("rd84", 32'h84, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
